l2_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the shared unified L2 cache. Port 0 is the L1 I-cache miss port (read-only in practice). Port 1 is the L1 D-cache miss/writeback port.
- Grants one 256-bit line transaction at a time and holds a registered, stable copy of the request on the L2 CPU-side interface until the L2 responds.
- Returns the L2 response to the granted requester one cycle later, from a registered line buffer.
- Sits between the L1 caches and the L2 cache, which already exposes a mem_address / mem_rdata256 / mem_wdata256 / mem_read / mem_write / mem_resp interface.

---
 rtl/cache_mux_types.sv | 19 +
 rtl/l2_arbiter_rr_pick.sv | 27 ++
 rtl/l2_arbiter.sv | 158 +++++++++++++++
 tb/tb_l2_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mux_types.sv
// Shared types for the L1/L2 cache multiplexing logic.
//   arb_state_t : sequencer states of l2_arbiter
//   arb_port_t  : requester identity, used for grants and round-robin history
package cache_mux_types;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

endpackage : cache_mux_types

// File: rtl/l2_arbiter_rr_pick.sv
// Combinational two-way round-robin grant selection.
//   req_i, req_d   : pending requests from the I-cache and D-cache ports
//   last_grant     : port that won the previous grant
//   grant_valid_c  : at least one request is pending
//   grant_port_c   : port to grant; on contention, the one that did not win last
module l2_arbiter_rr_pick
    import cache_mux_types::*;
(
    input  logic      req_i,
    input  logic      req_d,
    input  arb_port_t last_grant,
    output logic      grant_valid_c,
    output arb_port_t grant_port_c
);

    // Contention alternates; a lone request always wins.
    always_comb begin
        grant_valid_c = req_i | req_d;
        grant_port_c  = PORT_I;
        if (req_i && req_d) begin
            grant_port_c = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant_port_c = PORT_D;
        end
    end

endmodule : l2_arbiter_rr_pick

// File: rtl/l2_arbiter.sv
// Two-requester arbiter/sequencer in front of the unified L2 cache.
// Grants one line transaction at a time, presents a registered copy of the
// request to the L2 until mem_resp, then returns the response from a
// registered line buffer one cycle later.
//   clk, rst                    : clock, asynchronous active-low reset
//   i_* (address/read/write/wdata -> rdata/resp) : I-cache miss port
//   d_* (address/read/write/wdata -> rdata/resp) : D-cache miss/writeback port
//   l2_* (address/wdata/read/write <- rdata/resp): L2 CPU-side interface
module l2_arbiter
    import cache_mux_types::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    arb_state_t            state_q,      state_d;
    arb_port_t             last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  op_write_q,   op_write_d;
    logic [LINE_WIDTH-1:0] line_q,       line_d;
    logic                  l2_read_q,    l2_read_d;
    logic                  l2_write_q,   l2_write_d;
    logic                  i_resp_q,     i_resp_d;
    logic                  d_resp_q,     d_resp_d;

    logic                  grant_valid_c;
    arb_port_t             grant_port_c;

    l2_arbiter_rr_pick u_rr_pick (
        .req_i         (i_read | i_write),
        .req_d         (d_read | d_write),
        .last_grant    (last_grant_q),
        .grant_valid_c (grant_valid_c),
        .grant_port_c  (grant_port_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_write_d   = op_write_q;
        line_d       = line_q;
        l2_read_d    = 1'b0;
        l2_write_d   = 1'b0;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid_c) begin
                    last_grant_d = grant_port_c;
                    // Write wins if a requester asserts read and write together.
                    if (grant_port_c == PORT_I) begin
                        state_d    = SERVE_I;
                        addr_d     = i_address;
                        wdata_d    = i_wdata;
                        op_write_d = i_write;
                    end else begin
                        state_d    = SERVE_D;
                        addr_d     = d_address;
                        wdata_d    = d_wdata;
                        op_write_d = d_write;
                    end
                    l2_read_d  = ~op_write_d;
                    l2_write_d = op_write_d;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    if (!op_write_q) begin
                        line_d = l2_rdata;
                    end
                    if (state_q == SERVE_I) begin
                        state_d  = RESP_I;
                        i_resp_d = 1'b1;
                    end else begin
                        state_d  = RESP_D;
                        d_resp_d = 1'b1;
                    end
                end else begin
                    l2_read_d  = ~op_write_q;
                    l2_write_d = op_write_q;
                end
            end
            RESP_I, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            line_q       <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_write_q   <= op_write_d;
            line_q       <= line_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign l2_read    = l2_read_q;
    assign l2_write   = l2_write_q;
    assign i_resp     = i_resp_q;
    assign d_resp     = d_resp_q;
    // Both ports see the line buffer; only the resp pulse qualifies it.
    assign i_rdata    = line_q;
    assign d_rdata    = line_q;

endmodule : l2_arbiter

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
module tb_l2_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  i_address, d_address, l2_address;
    logic         i_read, i_write, d_read, d_write;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, l2_wdata, l2_rdata;
    logic         i_resp, d_resp, l2_read, l2_write, l2_resp;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] LINE_A = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] LINE_5 = {8{32'h5555_5555}};
    localparam logic [255:0] LINE_W = {8{32'h1234_5678}};
    localparam logic [255:0] LINE_F = {8{32'hFFFF_FFFF}};

    l2_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_address  (i_address),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_address  (d_address),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_address = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        tick();
        tick();
        total++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl got=%b want=0000", {l2_read, l2_write, i_resp, d_resp});
        end
        total++;
        if (l2_address !== 32'h0 || l2_wdata !== 256'h0 || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
            bad++; $display("FAIL reset_data addr=%h (want 0), data nonzero", l2_address);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
            bad++; $display("FAIL post_reset_idle got=%b want=0000", {l2_read, l2_write, i_resp, d_resp});
        end
    endtask

    // I read, L2 answers in the third SERVE cycle.
    task automatic test_i_read();
        i_address = 32'h0000_0040; i_read = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_address !== 32'h40 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
                bad++; $display("FAIL i_read_serve c=%0d rd=%b wr=%b addr=%h iresp=%b dresp=%b want 1 0 40 0 0",
                                c, l2_read, l2_write, l2_address, i_resp, d_resp);
            end
            if (c == 3) begin
                l2_resp = 1'b1; l2_rdata = LINE_A;
            end
        end
        tick();
        l2_resp = 1'b0; l2_rdata = '0;
        total++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || l2_read !== 1'b0 || i_rdata !== LINE_A) begin
            bad++; $display("FAIL i_read_resp iresp=%b dresp=%b rd=%b rdata=%h want 1 0 0 aaaa..", i_resp, d_resp, l2_read, i_rdata[31:0]);
        end
        i_read = 1'b0;
        tick();
        total++;
        if (i_resp !== 1'b0 || l2_read !== 1'b0 || i_rdata !== LINE_A) begin
            bad++; $display("FAIL i_read_after iresp=%b rd=%b rdata=%h want 0 0 aaaa..", i_resp, l2_read, i_rdata[31:0]);
        end
    endtask

    // D writeback with requester data changing during SERVE.
    task automatic test_d_write();
        d_address = 32'h8000_0020; d_write = 1'b1; d_wdata = LINE_W;
        tick();
        d_address = 32'hDEAD_0000; d_wdata = ~LINE_W;
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== LINE_W || l2_address !== 32'h8000_0020) begin
                bad++; $display("FAIL d_write_serve c=%0d wr=%b rd=%b addr=%h wdata=%h want 1 0 80000020 12345678",
                                c, l2_write, l2_read, l2_address, l2_wdata[31:0]);
            end
            if (c == 2) begin
                l2_resp = 1'b1; l2_rdata = LINE_5;
            end
            tick();
        end
        l2_resp = 1'b0;
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || l2_write !== 1'b0 || l2_read !== 1'b0 || d_rdata !== LINE_A) begin
            bad++; $display("FAIL d_write_resp dresp=%b iresp=%b wr=%b rd=%b rdata=%h want 1 0 0 0 aaaa..",
                            d_resp, i_resp, l2_write, l2_read, d_rdata[31:0]);
        end
        d_write = 1'b0;
        tick();
        total++;
        if (d_resp !== 1'b0 || l2_write !== 1'b0) begin
            bad++; $display("FAIL d_write_after dresp=%b wr=%b want 0 0", d_resp, l2_write);
        end
    endtask

    // Both ports held after reset: grants alternate I, D, I, D.
    task automatic test_contention();
        logic [255:0] line;
        logic         exp_i;
        rst = 1'b0; tick(); rst = 1'b1;
        i_address = 32'h0000_0100; d_address = 32'h0000_0200;
        i_read = 1'b1; d_read = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_i = (n % 2 == 0);
            line = {8{32'(n + 32'h1000)}};
            tick();
            total++;
            if (l2_read !== 1'b1 || l2_address !== (exp_i ? 32'h100 : 32'h200)) begin
                bad++; $display("FAIL contend_grant n=%0d rd=%b addr=%h want 1 %h", n, l2_read, l2_address,
                                exp_i ? 32'h100 : 32'h200);
            end
            l2_resp = 1'b1; l2_rdata = line;
            tick();
            l2_resp = 1'b0;
            total++;
            if (i_resp !== exp_i || d_resp !== !exp_i || i_rdata !== line || d_rdata !== line) begin
                bad++; $display("FAIL contend_resp n=%0d iresp=%b dresp=%b rdata=%h want %b %b %h",
                                n, i_resp, d_resp, i_rdata[31:0], exp_i, !exp_i, line[31:0]);
            end
            tick();
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();
        total++;
        if (l2_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            bad++; $display("FAIL contend_quiet rd=%b iresp=%b dresp=%b want 0 0 0", l2_read, i_resp, d_resp);
        end
    endtask

    // Asynchronous reset two cycles into SERVE_D.
    task automatic test_reset_mid();
        d_address = 32'h0000_0300; d_read = 1'b1;
        tick();
        tick();
        total++;
        if (l2_read !== 1'b1 || l2_address !== 32'h300) begin
            bad++; $display("FAIL mid_pre rd=%b addr=%h want 1 300", l2_read, l2_address);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_address !== 32'h0 || l2_wdata !== 256'h0
            || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
            bad++; $display("FAIL mid_reset ctl=%b addr=%h want 0000 0", {l2_read, l2_write, i_resp, d_resp}, l2_address);
        end
        d_read = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
            bad++; $display("FAIL mid_after ctl=%b want 0000", {l2_read, l2_write, i_resp, d_resp});
        end
    endtask

    // Read and write together on D: treated as a write, buffer untouched.
    task automatic test_rw_same_port();
        d_address = 32'h0000_0400; d_read = 1'b1; d_write = 1'b1; d_wdata = LINE_5;
        tick();
        total++;
        if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== LINE_5) begin
            bad++; $display("FAIL rw_serve wr=%b rd=%b wdata=%h want 1 0 55555555", l2_write, l2_read, l2_wdata[31:0]);
        end
        l2_resp = 1'b1; l2_rdata = LINE_F;
        tick();
        l2_resp = 1'b0;
        total++;
        if (d_resp !== 1'b1 || d_rdata !== 256'h0) begin
            bad++; $display("FAIL rw_resp dresp=%b rdata=%h want 1 00000000", d_resp, d_rdata[31:0]);
        end
        d_read = 1'b0; d_write = 1'b0;
        tick();
    endtask

    // Spurious l2_resp in IDLE is ignored; a following request is served normally.
    task automatic test_spurious();
        l2_resp = 1'b1; l2_rdata = LINE_F;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || i_rdata !== 256'h0) begin
                bad++; $display("FAIL spurious c=%0d ctl=%b rdata=%h want 0000 0", c, {l2_read, l2_write, i_resp, d_resp}, i_rdata[31:0]);
            end
        end
        l2_resp = 1'b0;
        i_address = 32'h0000_0500; i_read = 1'b1;
        tick();
        total++;
        if (l2_read !== 1'b1 || l2_address !== 32'h500) begin
            bad++; $display("FAIL spurious_next rd=%b addr=%h want 1 500", l2_read, l2_address);
        end
        l2_resp = 1'b1; l2_rdata = LINE_A;
        tick();
        l2_resp = 1'b0;
        total++;
        if (i_resp !== 1'b1 || i_rdata !== LINE_A) begin
            bad++; $display("FAIL spurious_resp iresp=%b rdata=%h want 1 aaaaaaaa", i_resp, i_rdata[31:0]);
        end
        i_read = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_reset_mid();
        test_rw_same_port();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_l2_arbiter
